// File: rtl/xor_stream_cipher_if.sv
// Serial cipher bus: enable, serial load inputs and ciphertext/status outputs.
//   master : drives ena, iData_in, iKey_flag, iMsg_flag, iMode; observes outputs
//   slave  : the cipher; drives oData_out, oData_flag, oKey_valid, oBusy, oDone
interface xor_stream_cipher_if;
    logic ena;
    logic iData_in;
    logic iKey_flag;
    logic iMsg_flag;
    logic iMode;
    logic oData_out;
    logic oData_flag;
    logic oKey_valid;
    logic oBusy;
    logic oDone;

    modport master (
        output ena, iData_in, iKey_flag, iMsg_flag, iMode,
        input  oData_out, oData_flag, oKey_valid, oBusy, oDone
    );

    modport slave (
        input  ena, iData_in, iKey_flag, iMsg_flag, iMode,
        output oData_out, oData_flag, oKey_valid, oBusy, oDone
    );
endinterface

// File: rtl/xor_stream_cipher.sv
// Serial XOR stream cipher: deserialises key and message (MSB first), XORs the
// message block-wise with a repeating or rolling key, and serialises the
// ciphertext MSB first.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : xor_stream_cipher_if.slave (enable, serial inputs, status outputs)
module xor_stream_cipher #(
    parameter int unsigned MSG_SIZE = 64,
    parameter int unsigned KEY_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    xor_stream_cipher_if.slave   bus
);

    localparam int unsigned NUM_BLK = MSG_SIZE / KEY_SIZE;
    localparam int unsigned KCW     = $clog2(KEY_SIZE + 1);
    localparam int unsigned MCW     = $clog2(MSG_SIZE + 1);
    localparam int unsigned BCW     = $clog2(NUM_BLK + 1);
    localparam int unsigned BITW    = $clog2(MSG_SIZE);

    localparam logic [KCW-1:0]  KEY_FULL = KCW'(KEY_SIZE);
    localparam logic [MCW-1:0]  MSG_FULL = MCW'(MSG_SIZE);
    localparam logic [BCW-1:0]  BLK_LAST = BCW'(NUM_BLK - 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(MSG_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENCRYPT = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e              state_q;
    logic [KEY_SIZE-1:0] key_q;
    logic [KEY_SIZE-1:0] wkey_q;
    logic [MSG_SIZE-1:0] msg_q;
    logic [MSG_SIZE-1:0] ct_q;
    logic [KCW-1:0]      key_cnt_q;
    logic [MCW-1:0]      msg_cnt_q;
    logic [BCW-1:0]      blk_cnt_q;
    logic [BITW-1:0]     bit_cnt_q;
    logic                key_flag_q;
    logic                msg_flag_q;
    logic                mode_q;
    logic                data_out_q;
    logic                data_flag_q;
    logic                key_valid_q;
    logic                busy_q;
    logic                done_q;

    logic [KEY_SIZE-1:0] blk_ct;
    logic [MSG_SIZE-1:0] ct_d;

    // Current block's ciphertext and the ciphertext register with it appended
    always_comb begin
        blk_ct = msg_q[MSG_SIZE-1 -: KEY_SIZE] ^ wkey_q;
        ct_d   = (ct_q << KEY_SIZE) | MSG_SIZE'(blk_ct);
    end

    // Control FSM and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            wkey_q      <= '0;
            msg_q       <= '0;
            ct_q        <= '0;
            key_cnt_q   <= '0;
            msg_cnt_q   <= '0;
            blk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            key_flag_q  <= 1'b0;
            msg_flag_q  <= 1'b0;
            mode_q      <= 1'b0;
            data_out_q  <= 1'b0;
            data_flag_q <= 1'b0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (bus.ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (msg_cnt_q == MSG_FULL && key_cnt_q == KEY_FULL) begin
                        state_q   <= ST_ENCRYPT;
                        mode_q    <= bus.iMode;
                        wkey_q    <= key_q;
                        blk_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end else begin
                        key_flag_q <= bus.iKey_flag;
                        msg_flag_q <= bus.iMsg_flag;
                        // Key load has priority; a simultaneous message bit is dropped
                        if (bus.iKey_flag) begin
                            if (!key_flag_q) begin
                                key_q       <= {key_q[KEY_SIZE-2:0], bus.iData_in};
                                key_cnt_q   <= KCW'(1);
                                key_valid_q <= 1'b0;
                            end else if (key_cnt_q != KEY_FULL) begin
                                key_q       <= {key_q[KEY_SIZE-2:0], bus.iData_in};
                                key_cnt_q   <= key_cnt_q + KCW'(1);
                                key_valid_q <= (key_cnt_q == KEY_FULL - KCW'(1));
                            end
                        end else if (bus.iMsg_flag) begin
                            if (!msg_flag_q) begin
                                msg_q     <= {msg_q[MSG_SIZE-2:0], bus.iData_in};
                                msg_cnt_q <= MCW'(1);
                            end else if (msg_cnt_q != MSG_FULL) begin
                                msg_q     <= {msg_q[MSG_SIZE-2:0], bus.iData_in};
                                msg_cnt_q <= msg_cnt_q + MCW'(1);
                            end
                        end
                    end
                end

                ST_ENCRYPT: begin
                    ct_q      <= ct_d;
                    msg_q     <= msg_q << KEY_SIZE;
                    blk_cnt_q <= blk_cnt_q + BCW'(1);
                    if (mode_q) begin
                        wkey_q <= {wkey_q[KEY_SIZE-2:0], wkey_q[KEY_SIZE-1]};
                    end
                    // First ciphertext bit goes out together with the last block
                    if (blk_cnt_q == BLK_LAST) begin
                        state_q     <= ST_SHIFT;
                        bit_cnt_q   <= '0;
                        data_flag_q <= 1'b1;
                        data_out_q  <= ct_d[MSG_SIZE-1];
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_q     <= ST_DONE;
                        data_flag_q <= 1'b0;
                        data_out_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        ct_q       <= ct_q << 1;
                        data_out_q <= ct_q[MSG_SIZE-2];
                        bit_cnt_q  <= bit_cnt_q + BITW'(1);
                    end
                end

                ST_DONE: begin
                    done_q    <= 1'b0;
                    msg_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.oData_out  = data_out_q;
    assign bus.oData_flag = data_flag_q;
    assign bus.oKey_valid = key_valid_q;
    assign bus.oBusy      = busy_q;
    assign bus.oDone      = done_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed self-checking bench for xor_stream_cipher (MSG_SIZE=64, KEY_SIZE=8).
module tb_xor_stream_cipher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    xor_stream_cipher_if bus();

    xor_stream_cipher #(.MSG_SIZE(64), .KEY_SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] k);
        bus.iKey_flag = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bus.iData_in = k[i];
            tick();
        end
        bus.iKey_flag = 1'b0;
        bus.iData_in  = 1'b0;
        tick();
    endtask

    // Leaves the bench just after the edge that samples the last message bit
    task automatic send_msg(input logic [63:0] m);
        bus.iMsg_flag = 1'b1;
        for (int i = 63; i >= 0; i--) begin
            bus.iData_in = m[i];
            tick();
        end
        bus.iMsg_flag = 1'b0;
        bus.iData_in  = 1'b0;
    endtask

    // Collects serial ciphertext; optionally offers junk message bits meanwhile
    task automatic capture(input logic noise, output logic [63:0] ct, output int lat,
                           output int flen, output int dcnt, output logic busy_seen);
        ct = '0; lat = 0; flen = 0; dcnt = 0;
        if (noise) begin
            bus.iMsg_flag = 1'b1;
            bus.iData_in  = 1'b1;
        end
        while (!bus.oData_flag && lat < 200) begin
            tick();
            lat++;
        end
        busy_seen = bus.oBusy;
        for (int i = 0; i < 64; i++) begin
            if (bus.oData_flag) flen++;
            ct = {ct[62:0], bus.oData_out};
            tick();
        end
        bus.iMsg_flag = 1'b0;
        bus.iData_in  = 1'b0;
        while (bus.oData_flag && flen < 200) begin
            flen++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.oDone) dcnt++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [63:0] ct;
    int          lat, flen, dcnt;
    logic        busy_seen;
    logic [63:0] outs;

    initial begin
        bus.ena       = 1'b1;
        bus.iData_in  = 1'b0;
        bus.iKey_flag = 1'b0;
        bus.iMsg_flag = 1'b0;
        bus.iMode     = 1'b0;
        #3;
        outs = {59'd0, bus.oData_out, bus.oData_flag, bus.oKey_valid, bus.oBusy, bus.oDone};
        check("reset_outputs", outs, 64'd0);
        check("reset_state", 64'(dut.state_q), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: repeating key
        send_key(8'hAC);
        check("t1_key_valid", 64'(bus.oKey_valid), 64'd1);
        send_msg(64'h0123456789ABCDEF);
        capture(1'b0, ct, lat, flen, dcnt, busy_seen);
        check("t1_ct", ct, 64'hAD8FE9CB25076143);
        check("t1_latency", 64'(lat), 64'd9);
        check("t1_flag_len", 64'(flen), 64'd64);
        check("t1_done_cnt", 64'(dcnt), 64'd1);
        check("t1_busy", 64'(busy_seen), 64'd1);

        // 2: rolling key, key reused from scenario 1
        bus.iMode = 1'b1;
        send_msg(64'h0);
        capture(1'b0, ct, lat, flen, dcnt, busy_seen);
        bus.iMode = 1'b0;
        check("t2_ct", ct, 64'hAC59B265CA952B56);

        // 3: message before key
        do_reset();
        send_msg(64'h0123456789ABCDEF);
        tick(); tick(); tick();
        check("t3_wait_busy", 64'(bus.oBusy), 64'd0);
        check("t3_wait_state", 64'(dut.state_q), 64'd0);
        check("t3_wait_kv", 64'(bus.oKey_valid), 64'd0);
        send_key(8'hAC);
        capture(1'b0, ct, lat, flen, dcnt, busy_seen);
        check("t3_ct", ct, 64'hAD8FE9CB25076143);

        // 4: simultaneous flags, key wins (key bits 1,0,1 of 0xAC)
        do_reset();
        bus.iKey_flag = 1'b1;
        bus.iMsg_flag = 1'b1;
        bus.iData_in = 1'b1; tick();
        bus.iData_in = 1'b0; tick();
        bus.iData_in = 1'b1; tick();
        check("t4_key_cnt", 64'(dut.key_cnt_q), 64'd3);
        check("t4_msg_cnt", 64'(dut.msg_cnt_q), 64'd0);
        bus.iMsg_flag = 1'b0;
        bus.iData_in = 1'b0; tick();
        bus.iData_in = 1'b1; tick();
        bus.iData_in = 1'b1; tick();
        bus.iData_in = 1'b0; tick();
        bus.iData_in = 1'b0; tick();
        bus.iKey_flag = 1'b0;
        tick();
        check("t4_key", 64'(dut.key_q), 64'hAC);
        send_msg(64'h0123456789ABCDEF);
        capture(1'b0, ct, lat, flen, dcnt, busy_seen);
        check("t4_ct", ct, 64'hAD8FE9CB25076143);

        // 5: key reload, then key reuse with junk offered during SHIFT
        do_reset();
        send_key(8'hFF);
        send_key(8'h0F);
        check("t5_key", 64'(dut.key_q), 64'h0F);
        check("t5_key_cnt", 64'(dut.key_cnt_q), 64'd8);
        send_msg(64'h0123456789ABCDEF);
        capture(1'b0, ct, lat, flen, dcnt, busy_seen);
        check("t5_ct1", ct, 64'h0E2C4A6886A4C2E0);
        send_msg(64'hFFFFFFFFFFFFFFFF);
        capture(1'b1, ct, lat, flen, dcnt, busy_seen);
        check("t5_ct2", ct, 64'hF0F0F0F0F0F0F0F0);
        check("t5_msg_cnt_after", 64'(dut.msg_cnt_q), 64'd0);
        check("t5_done_cnt", 64'(dcnt), 64'd1);

        // 6: reset at SHIFT bit 20, then loads with ena low
        send_msg(64'h0123456789ABCDEF);
        lat = 0;
        while (!bus.oData_flag && lat < 200) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 20; i++) tick();
        check("t6_mid_flag", 64'(bus.oData_flag), 64'd1);
        rst = 1'b1;
        #1;
        outs = {59'd0, bus.oData_out, bus.oData_flag, bus.oKey_valid, bus.oBusy, bus.oDone};
        check("t6_async_outs", outs, 64'd0);
        check("t6_state", 64'(dut.state_q), 64'd0);
        tick();
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.oDone) dcnt++;
            tick();
        end
        check("t6_no_done", 64'(dcnt), 64'd0);
        bus.ena = 1'b0;
        send_key(8'hAC);
        send_msg(64'h0123456789ABCDEF);
        tick();
        check("t6_frozen_key_cnt", 64'(dut.key_cnt_q), 64'd0);
        check("t6_frozen_msg_cnt", 64'(dut.msg_cnt_q), 64'd0);
        check("t6_frozen_kv", 64'(bus.oKey_valid), 64'd0);
        bus.ena = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
